stage_fetch: RTL
================

STAGE_FETCH -- requirements
Module: stage_fetch

Interface
REQ-001 Parameter RESET_PC: default 32'h0000_0000; fetch address loaded on reset.
REQ-002 Parameter BTB_ENTRIES: default 16; predictor entry count, power of two, at least 2; IDX = log2(BTB_ENTRIES).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high. The ports are named clk and rst.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 stall  in  1  hold the current PC; asserted by the hazard unit.
REQ-007 redirect  in  1  execute-stage mispredict or jump correction.
REQ-008 redirectPc  in  32  corrected fetch address.
REQ-009 updateEn  in  1  resolved-branch predictor update strobe.
REQ-010 updatePc  in  32  address of the resolved branch or jump.
REQ-011 updateTaken  in  1  resolved direction.
REQ-012 updateTarget  in  32  resolved target address.
REQ-013 imemAddr  out  32  instruction memory address (combinational read).
REQ-014 imemData  in  32  instruction word for imemAddr, valid in the same cycle.
REQ-015 instrF  out  32  fetched instruction to the decode stage.
REQ-016 pcF  out  32  address of instrF.
REQ-017 pcPlus4F  out  32  pcF + 4.
REQ-018 bPredictedTakenF  out  1  prediction made for instrF.

Function
REQ-019 The PC register SHALL drive imemAddr and pcF. instrF SHALL equal imemData, and pcPlus4F SHALL equal pc + 4 modulo 2^32 (wraps from 32'hFFFF_FFFC to 0).
REQ-020 BTB organisation: direct-mapped; index = pc[IDX+1:2]; tag = pc[31:IDX+2]; each entry holds valid, tag, target[31:0] and a 2-bit saturating counter ctr.
REQ-021 Lookup SHALL be combinational on pc: hit = valid && tag match; bPredictedTakenF = hit && ctr[1].
REQ-022 Next-PC priority SHALL be, highest first: redirect -> redirectPc; stall -> pc; bPredictedTakenF -> entry target; otherwise pc + 4.
REQ-023 redirect SHALL override stall in the same cycle.
REQ-024 Fetch latency SHALL be zero cycles: a new PC value appears on the outputs in the cycle after the edge that loads it.
REQ-025 Update on a hit at updatePc (clock edge with updateEn=1): ctr increments if updateTaken and decrements otherwise, saturating at 2'b11 and 2'b00; the target is rewritten when updateTaken=1.
REQ-026 Update on a miss with updateTaken=1: allocate or replace the entry with valid=1, tag, target, ctr=2'b10.
REQ-027 Update on a miss with updateTaken=0: the entry SHALL be left unchanged.
REQ-028 Same-index lookup and update in one cycle: the lookup SHALL use the pre-update contents; the write takes effect at the edge.
REQ-029 The update SHALL be applied independently of stall and redirect.
REQ-030 The block SHALL NOT check target alignment; the target and redirectPc are used verbatim.

Reset
REQ-031 While rst=1, asynchronously: pc = RESET_PC; all valid bits = 0; all ctr = 2'b01.
REQ-032 Outputs under reset SHALL be: pcF = RESET_PC, pcPlus4F = RESET_PC+4, bPredictedTakenF = 0, instrF = imemData.
REQ-033 Reset asserted mid-operation SHALL discard any pending redirect or update in the same cycle.
REQ-034 Target fields MAY be left unreset.

Verification
REQ-035 Reset, then free-run with no stall: pcF sequence 0, 4, 8, 12; bPredictedTakenF = 0 throughout.
REQ-036 stall=1 for 3 cycles at pcF=8: pcF holds at 8; the cycle after release pcF = 12. Applying stall and redirect (redirectPc=32'h100) together: the next pcF = 32'h100.
REQ-037 Update pc=32'h20 taken to target 32'h80 (alloc, ctr=10). Then fetch reaches 32'h20: bPredictedTakenF=1, and the next pcF = 32'h80.
REQ-038 Counter saturation: from ctr=10, apply three not-taken updates (ctr -> 01, 00, 00). Fetch at 32'h20: no prediction, next pcF = 32'h24.
REQ-039 Aliasing with 16 entries: the entry for 32'h20 is valid; fetch at 32'h60 (same index, different tag) gives bPredictedTakenF=0. A not-taken update at 32'h60 leaves the 32'h20 entry intact.
REQ-040 Same-cycle lookup and allocate at the current pc: no prediction that cycle; the following revisit is predicted taken. Asserting rst mid-run returns pcF to RESET_PC immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/stage_fetch.sv
// Fetch stage: PC register, next-PC selection and a direct-mapped branch target
// buffer with 2-bit saturating counters, looked up combinationally on the current PC.
module stage_fetch #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BTB_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirectPc,
    input  logic        updateEn,
    input  logic [31:0] updatePc,
    input  logic        updateTaken,
    input  logic [31:0] updateTarget,
    output logic [31:0] imemAddr,
    input  logic [31:0] imemData,
    output logic [31:0] instrF,
    output logic [31:0] pcF,
    output logic [31:0] pcPlus4F,
    output logic        bPredictedTakenF
);

    localparam int IDX  = $clog2(BTB_ENTRIES);
    localparam int TAGW = 30 - IDX;

    logic [31:0] pc;
    logic [31:0] pcNext;

    logic [BTB_ENTRIES-1:0]                 btbValid;
    logic [BTB_ENTRIES-1:0][TAGW-1:0]       btbTag;
    logic [BTB_ENTRIES-1:0][31:0]           btbTarget;
    logic [BTB_ENTRIES-1:0][1:0]            btbCtr;

    logic [IDX-1:0]  fetchIdx;
    logic [TAGW-1:0] fetchTag;
    logic            fetchHit;

    logic [IDX-1:0]  updIdx;
    logic [TAGW-1:0] updTag;
    logic            updHit;
    logic [1:0]      updCtrOld;
    logic [1:0]      updCtrNew;
    logic            unusedUpdLow;

    assign fetchIdx = pc[IDX+1:2];
    assign fetchTag = pc[31:IDX+2];
    assign fetchHit = btbValid[fetchIdx] && (btbTag[fetchIdx] == fetchTag);
    assign bPredictedTakenF = fetchHit && btbCtr[fetchIdx][1];

    assign updIdx       = updatePc[IDX+1:2];
    assign updTag       = updatePc[31:IDX+2];
    assign updHit       = btbValid[updIdx] && (btbTag[updIdx] == updTag);
    assign updCtrOld    = btbCtr[updIdx];
    assign unusedUpdLow = ^updatePc[1:0];

    always_comb begin
        updCtrNew = updCtrOld;
        if (updateTaken) begin
            if (updCtrOld != 2'b11) updCtrNew = updCtrOld + 2'b01;
        end else begin
            if (updCtrOld != 2'b00) updCtrNew = updCtrOld - 2'b01;
        end
    end

    // Redirect beats stall, stall beats the prediction.
    always_comb begin
        if (redirect)
            pcNext = redirectPc;
        else if (stall)
            pcNext = pc;
        else if (bPredictedTakenF)
            pcNext = btbTarget[fetchIdx];
        else
            pcNext = pc + 32'd4;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pc <= RESET_PC;
        else
            pc <= pcNext;
    end

    genvar gi;
    generate
        for (gi = 0; gi < BTB_ENTRIES; gi++) begin : gEntry
            logic            entryValid;
            logic [TAGW-1:0] entryTag;
            logic [31:0]     entryTarget;
            logic [1:0]      entryCtr;
            logic            entrySel;

            assign entrySel = updateEn && (updIdx == IDX'(gi));

            // Not-taken misses leave the entry alone so a live branch is not evicted.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    entryValid <= 1'b0;
                    entryTag   <= '0;
                    entryCtr   <= 2'b01;
                end else if (entrySel) begin
                    if (updHit) begin
                        entryCtr <= updCtrNew;
                    end else if (updateTaken) begin
                        entryValid <= 1'b1;
                        entryTag   <= updTag;
                        entryCtr   <= 2'b10;
                    end
                end
            end

            // Targets carry no reset; they are only consulted behind a valid bit.
            always_ff @(posedge clk) begin
                if (entrySel && updateTaken && !rst)
                    entryTarget <= updateTarget;
            end

            assign btbValid[gi]  = entryValid;
            assign btbTag[gi]    = entryTag;
            assign btbTarget[gi] = entryTarget;
            assign btbCtr[gi]    = entryCtr;
        end
    endgenerate

    assign imemAddr = pc;
    assign pcF      = pc;
    assign pcPlus4F = pc + 32'd4;
    assign instrF   = imemData;

endmodule
